// File: rtl/timer_input_conditioner.sv
// Stopwatch front end: divides clk into a count-enable tick, conditions the start/stop
// and clear pushbuttons into single-cycle press pulses, and tracks the run/pause state.
module timer_input_conditioner #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_stop,
    input  logic btn_clear,
    output logic tick,
    output logic run_tick,
    output logic stop_pulse,
    output logic clear_pulse,
    output logic run
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic RELEASED = BTN_ACTIVE_LOW;

    logic [1:0]       raw_btn;
    logic [1:0]       btn_pulse;
    logic [DIV_W-1:0] div_count;

    assign raw_btn = {btn_clear, btn_stop};

    // Index 0 is start/stop, index 1 is clear; both buttons share one conditioning chain.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync_meta;
        logic            sync_out;
        logic            pressed;
        logic            stable;
        logic            stable_prev;
        logic            pulse_q;
        logic [DB_W-1:0] db_count;

        // Preset to the released level so leaving reset never looks like a press edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_meta <= RELEASED;
                sync_out  <= RELEASED;
            end else begin
                sync_meta <= raw_btn[b];
                sync_out  <= sync_meta;
            end
        end

        assign pressed = sync_out ^ BTN_ACTIVE_LOW;

        // Any cycle matching the stable state restarts the count, so bounces never accumulate.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stable   <= 1'b0;
                db_count <= '0;
            end else if (pressed == stable) begin
                db_count <= '0;
            end else if (db_count == DB_LAST) begin
                stable   <= pressed;
                db_count <= '0;
            end else begin
                db_count <= db_count + DB_W'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stable_prev <= 1'b0;
                pulse_q     <= 1'b0;
            end else begin
                stable_prev <= stable;
                pulse_q     <= stable & ~stable_prev;
            end
        end

        assign btn_pulse[b] = pulse_q;
    end

    assign stop_pulse  = btn_pulse[0];
    assign clear_pulse = btn_pulse[1];

    // Clear restarts the period so the first tick after it is a full TICK_DIV away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_count <= '0;
            tick      <= 1'b0;
        end else if (clear_pulse) begin
            div_count <= '0;
            tick      <= 1'b0;
        end else if (div_count == DIV_LAST) begin
            div_count <= '0;
            tick      <= 1'b1;
        end else begin
            div_count <= div_count + DIV_W'(1);
            tick      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run <= 1'b0;
        end else if (clear_pulse) begin
            run <= 1'b0;
        end else if (stop_pulse) begin
            run <= ~run;
        end
    end

    assign run_tick = tick & run;

endmodule

// File: tb/tb_timer_input_conditioner.sv
// Self-checking bench for timer_input_conditioner: directed press/bounce/reset scenarios
// plus randomized button activity, checked against a sample-window behavioural model.
module tb_timer_input_conditioner;

    localparam int TD = 10;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset;
    logic btn_stop;
    logic btn_clear;
    logic tick;
    logic run_tick;
    logic stop_pulse;
    logic clear_pulse;
    logic run;

    int n_checks = 0;
    int n_passed = 0;
    bit check_en = 1'b0;

    timer_input_conditioner #(
        .TICK_DIV       (TD),
        .DEBOUNCE_CYCLES(DB),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_stop   (btn_stop),
        .btn_clear  (btn_clear),
        .tick       (tick),
        .run_tick   (run_tick),
        .stop_pulse (stop_pulse),
        .clear_pulse(clear_pulse),
        .run        (run)
    );

    always #5 clk = ~clk;

    // Model state: raw pressed samples per button, accepted level, pending/active press pulse.
    bit hist [2][$];
    bit m_stable [2];
    bit m_rise   [2];
    bit m_pulse  [2];
    bit m_run;
    bit m_tick;
    int m_since;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            hist[b].delete();
            for (int i = 0; i < DB + 2; i++) hist[b].push_back(1'b0);
            m_stable[b] = 1'b0;
            m_rise[b]   = 1'b0;
            m_pulse[b]  = 1'b0;
        end
        m_run   = 1'b0;
        m_tick  = 1'b0;
        m_since = 0;
    endtask

    // A button level is accepted once DB consecutive synchronised samples all disagree
    // with the current level; the synchroniser makes the newest two samples not yet visible.
    task automatic model_step();
        bit pressed [2];
        bit all_diff;
        pressed[0] = (btn_stop == 1'b0);
        pressed[1] = (btn_clear == 1'b0);
        if (m_pulse[1]) begin
            m_since = 0;
            m_run   = 1'b0;
        end else begin
            m_since++;
            if (m_pulse[0]) m_run = !m_run;
        end
        m_tick = (m_since != 0) && (m_since % TD == 0);
        for (int b = 0; b < 2; b++) begin
            hist[b].push_back(pressed[b]);
            if (hist[b].size() > DB + 2) void'(hist[b].pop_front());
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++)
                if (hist[b][i] == m_stable[b]) all_diff = 1'b0;
            m_pulse[b] = m_rise[b];
            m_rise[b]  = 1'b0;
            if (all_diff) begin
                m_stable[b] = !m_stable[b];
                m_rise[b]   = m_stable[b];
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic check_output(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual === expected) n_passed++;
        else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("tick", tick, m_tick);
            check_output("run", run, m_run);
            check_output("stop_pulse", stop_pulse, m_pulse[0]);
            check_output("clear_pulse", clear_pulse, m_pulse[1]);
            check_output("run_tick", run_tick, m_tick & m_run);
        end
    end

    // Called at a negedge: drive mid-cycle, then advance the given number of clock edges.
    task automatic apply_stimulus(input logic stop, input logic clear, input logic rst,
                                  input int cycles);
        #3;
        btn_stop  = stop;
        btn_clear = clear;
        reset     = rst;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_cycles(input int n, output int ticks, output int run_ticks,
                                output int pulses);
        ticks = 0;
        run_ticks = 0;
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            ticks += int'(tick);
            run_ticks += int'(run_tick);
            pulses += int'(stop_pulse) + int'(clear_pulse);
        end
    endtask

    initial begin
        int ticks, run_ticks, pulses;
        bit rst_r, stop_r, clear_r;
        int hold;

        reset = 1'b1;
        btn_stop = 1'b1;
        btn_clear = 1'b1;
        wait_cycles(2);
        check_en = 1'b1;
        wait_cycles(1);
        check_output("reset_tick", tick, 1'b0);
        check_output("reset_run", run, 1'b0);
        check_output("reset_stop_pulse", stop_pulse, 1'b0);

        $display("[TB] idle after reset");
        apply_stimulus(1'b1, 1'b1, 1'b0, 9);
        check_output("t1_tick_edge9", tick, 1'b0);
        wait_cycles(1);
        check_output("t1_tick_edge10", tick, 1'b1);
        count_cycles(30, ticks, run_ticks, pulses);
        check_count("t1_ticks_edges11_40", ticks, 3);
        check_count("t1_run_ticks", run_ticks, 0);
        check_count("t1_pulses", pulses, 0);

        $display("[TB] clean stop press");
        apply_stimulus(1'b0, 1'b1, 1'b0, 6);
        check_output("t2_pulse_edge6", stop_pulse, 1'b0);
        wait_cycles(1);
        check_output("t2_pulse_edge7", stop_pulse, 1'b1);
        wait_cycles(1);
        check_output("t2_pulse_edge8", stop_pulse, 1'b0);
        check_output("t2_run", run, 1'b1);
        count_cycles(20, ticks, run_ticks, pulses);
        check_count("t2_run_ticks", run_ticks, 2);
        check_count("t2_held_pulses", pulses, 0);

        $display("[TB] second press pauses");
        apply_stimulus(1'b1, 1'b1, 1'b0, 10);
        check_output("t4_run_after_release", run, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 7);
        check_output("t4_pulse_edge7", stop_pulse, 1'b1);
        wait_cycles(1);
        check_output("t4_run_paused", run, 1'b0);
        count_cycles(20, ticks, run_ticks, pulses);
        check_count("t4_ticks", ticks, 2);
        check_count("t4_run_ticks", run_ticks, 0);

        $display("[TB] bouncing stop press");
        apply_stimulus(1'b1, 1'b1, 1'b0, 10);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 6);
        check_output("t3_pulse_edge6", stop_pulse, 1'b0);
        wait_cycles(1);
        check_output("t3_pulse_edge7", stop_pulse, 1'b1);
        wait_cycles(1);
        check_output("t3_run", run, 1'b1);

        $display("[TB] simultaneous stop and clear");
        apply_stimulus(1'b1, 1'b1, 1'b0, 10);
        check_output("t5_run_before", run, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 7);
        check_output("t5_stop_pulse", stop_pulse, 1'b1);
        check_output("t5_clear_pulse", clear_pulse, 1'b1);
        wait_cycles(1);
        check_output("t5_run_cleared", run, 1'b0);
        wait_cycles(9);
        check_output("t5_tick_edge17", tick, 1'b0);
        wait_cycles(1);
        check_output("t5_tick_restart", tick, 1'b1);

        $display("[TB] reset during held press");
        apply_stimulus(1'b1, 1'b1, 1'b0, 10);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8);
        check_output("t6_run_before_reset", run, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 2);
        check_output("t6_reset_run", run, 1'b0);
        check_output("t6_reset_tick", tick, 1'b0);
        check_output("t6_reset_stop_pulse", stop_pulse, 1'b0);
        check_output("t6_reset_run_tick", run_tick, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 6);
        check_output("t6_pulse_edge6", stop_pulse, 1'b0);
        wait_cycles(1);
        check_output("t6_pulse_edge7", stop_pulse, 1'b1);

        $display("[TB] randomized button activity");
        apply_stimulus(1'b1, 1'b1, 1'b0, 10);
        for (int i = 0; i < 120; i++) begin
            rst_r   = ($urandom_range(0, 39) == 0);
            stop_r  = 1'($urandom_range(0, 1));
            clear_r = ($urandom_range(0, 3) != 0);
            hold    = rst_r ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 9));
            apply_stimulus(stop_r, clear_r, rst_r, hold);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 12);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
